reg_file: RTL and testbench

//  Integer register file for the single-cycle CPU; sits directly upstream of the ALU operand-B mux.

---
 rtl/reg_file.sv | 107 ++++++++++
 tb/tb_reg_file.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Integer register file with two read ports, one write port, a debug read port and a
// sequential post-reset clear engine. Define RF_BYPASS_EN to forward same-cycle write data to reads.
module reg_file #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rR1,
  input  logic [ADDR_W-1:0] rR2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wR,
  input  logic [DATA_W-1:0] WD,
  output logic              ready,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  // state | meaning
  // CLEAR | zeroing one register per cycle, ports read 0, writes dropped
  // IDLE  | clear complete, normal read/write operation
  typedef enum logic {CLEAR, IDLE} state_t;

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic              clr_en, wr_en;
  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= ADDR_W'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    clr_en    = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_en = !rst;
        // Hold the index at the last entry instead of wrapping when leaving CLEAR.
        if (clr_idx_q == LAST_IDX) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        wr_en = we && ready_q && (wR != '0) && !rst;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_en) begin
      regs_q[clr_idx_q] <= '0;
    end else if (wr_en) begin
      regs_q[wR] <= WD;
    end
  end

  logic [ADDR_W-1:0] raddr [3];
  logic [DATA_W-1:0] rdata [3];

  assign raddr[0] = rR1;
  assign raddr[1] = rR2;
  assign raddr[2] = dbg_addr;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = '0;
      if (state_q == IDLE && raddr[p] != '0) begin
        rdata[p] = regs_q[raddr[p]];
`ifdef RF_BYPASS_EN
        if (we && ready_q && wR == raddr[p]) begin
          rdata[p] = WD;
        end
`endif
      end
    end
  end

  assign RD1      = rdata[0];
  assign RD2      = rdata[1];
  assign dbg_data = rdata[2];
  assign ready    = ready_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: clear engine timing, reads, writes,
// x0 guard, same-cycle read-after-write and writes dropped during clear.
module tb_reg_file;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rR1, rR2, wR, dbg_addr;
  logic [DATA_W-1:0] RD1, RD2, WD, dbg_data;
  logic              we, ready;

  int checks = 0;
  int errors = 0;

  reg_file #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .rR1(rR1), .rR2(rR2), .RD1(RD1), .RD2(RD2),
    .we(we), .wR(wR), .WD(WD), .ready(ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic count_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    we = 1'b1; wR = a; WD = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rR1 = ADDR_W'(i); rR2 = ADDR_W'(31 - i); dbg_addr = ADDR_W'(i);
      #1;
      checks += 3;
      if (RD1 !== '0) begin errors++; $display("FAIL %s RD1[%0d] got %h want 0", tag, i, RD1); end
      if (RD2 !== '0) begin errors++; $display("FAIL %s RD2[%0d] got %h want 0", tag, 31 - i, RD2); end
      if (dbg_data !== '0) begin errors++; $display("FAIL %s dbg[%0d] got %h want 0", tag, i, dbg_data); end
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    @(negedge clk);
    rst = 1'b0;
    count_ready(n);
    checks++;
    if (n != 31) begin errors++; $display("FAIL initial_clear_edges got %0d want 31", n); end
    // preload junk then clear again
    for (int i = 1; i < 32; i++) wr(ADDR_W'(i), 32'hA5A5_0000 + DATA_W'(i));
    rR1 = 5; #1;
    checks++;
    if (RD1 !== 32'hA5A5_0005) begin errors++; $display("FAIL junk_preload got %h want a5a50005", RD1); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 2;
    if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ready); end
    if (RD1 !== '0) begin errors++; $display("FAIL read_in_clear got %h want 0", RD1); end
    @(negedge clk);
    rst = 1'b0;
    count_ready(n);
    checks++;
    if (n != 31) begin errors++; $display("FAIL clear_edges got %0d want 31", n); end
    check_all_zero("reset_clear");
  endtask

  task automatic test_basic;
    @(negedge clk);
    we = 1'b1; wR = 5; WD = 32'hDEAD_BEEF; rR1 = 5; rR2 = 5;
    #1;
    checks++;
`ifdef RF_BYPASS_EN
    if (RD2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_pre RD2 got %h want deadbeef", RD2); end
`else
    if (RD2 !== 32'h0) begin errors++; $display("FAIL basic_pre RD2 got %h want 0", RD2); end
`endif
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    checks += 2;
    if (RD2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic RD2 got %h want deadbeef", RD2); end
    if (RD1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic RD1 got %h want deadbeef", RD1); end
  endtask

  task automatic test_x0;
    @(negedge clk);
    we = 1'b1; wR = 0; WD = 32'hFFFF_FFFF; rR1 = 0; dbg_addr = 0;
    #1;
    checks += 2;
    if (RD1 !== '0) begin errors++; $display("FAIL x0_pre RD1 got %h want 0", RD1); end
    if (dbg_data !== '0) begin errors++; $display("FAIL x0_pre dbg got %h want 0", dbg_data); end
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    checks++;
    if (RD1 !== '0) begin errors++; $display("FAIL x0_post RD1 got %h want 0", RD1); end
  endtask

  task automatic test_raw;
    wr(7, 32'h1);
    @(negedge clk);
    we = 1'b1; wR = 7; WD = 32'h2; rR1 = 7;
    #1;
    checks++;
`ifdef RF_BYPASS_EN
    if (RD1 !== 32'h2) begin errors++; $display("FAIL raw_pre RD1 got %h want 2", RD1); end
`else
    if (RD1 !== 32'h1) begin errors++; $display("FAIL raw_pre RD1 got %h want 1", RD1); end
`endif
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    checks++;
    if (RD1 !== 32'h2) begin errors++; $display("FAIL raw_post RD1 got %h want 2", RD1); end
  endtask

  task automatic test_mid_clear;
    int n;
    wr(20, 32'h1234_5678);
    wr(31, 32'h8765_4321);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // nine clear edges take the index from 1 to 10
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL mid_clear_ready got %b want 0", ready); end
    count_ready(n);
    checks++;
    if (n != 31) begin errors++; $display("FAIL mid_clear_edges got %0d want 31", n); end
    check_all_zero("mid_clear");
  endtask

  task automatic test_write_during_clear;
    int n;
    wr(3, 32'h77);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    we = 1'b1; wR = 3; WD = 32'h55;
    count_ready(n);
    we = 1'b0;
    checks++;
    if (n > 30) begin errors++; $display("FAIL wdc_ready_timeout got %0d want <=30", n); end
    rR1 = 3; dbg_addr = 3;
    #1;
    checks += 2;
    if (RD1 !== '0) begin errors++; $display("FAIL wdc RD1 got %h want 0", RD1); end
    if (dbg_data !== '0) begin errors++; $display("FAIL wdc dbg got %h want 0", dbg_data); end
  endtask

  task automatic test_rst_and_write;
    @(negedge clk);
    rst = 1'b1; we = 1'b1; wR = 9; WD = 32'hCAFE_F00D;
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rR1 = 9;
    #1;
    checks += 2;
    if (ready !== 1'b1) begin errors++; $display("FAIL rstw_ready got %b want 1", ready); end
    if (RD1 !== '0) begin errors++; $display("FAIL rstw RD1 got %h want 0", RD1); end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wR = '0; WD = '0; rR1 = '0; rR2 = '0; dbg_addr = '0;
    test_reset();
    test_basic();
    test_x0();
    test_raw();
    test_mid_clear();
    test_write_during_clear();
    test_rst_and_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
